// File: rtl/bmc_pkg.sv
// -----------------------------------------------------------------------------
// bmc_pkg
// Shared types and default constants for the biphase-mark decode controller.
//   state_t    : lock/framing FSM states (IDLE, SYNC, BIT_START, HALF)
//   iv_class_t : classification of a measured edge interval
//                (NONE, SHORT = half-bit, LONG = full-bit, TIMEOUT)
// Optional feature macro used by the top: BMC_STATS_EN.
// -----------------------------------------------------------------------------
package bmc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC      = 2'd1,
        BIT_START = 2'd2,
        HALF      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        SHORT   = 2'd1,
        LONG    = 2'd2,
        TIMEOUT = 2'd3
    } iv_class_t;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_SHORT_MAX = 12;
    localparam int DEF_LONG_MAX  = 24;

endpackage

// File: rtl/bmc_decode_ctrl_interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Measures the number of cycles between successive edges and classifies each
// interval. Emits a one-cycle strobe with a class on every edge, and on the
// cycle the counter reaches LONG_MAX+1 while the decoder is active (timeout).
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   enable         : low flushes the counter to 0 and suppresses strobes
//   active         : decoder is outside IDLE; timeouts only count when set
//   any_edge       : rising or falling edge seen this cycle
//   iv_class       : class of the interval closed this cycle
//   iv_strobe      : iv_class is valid this cycle
// -----------------------------------------------------------------------------
module interval_timer
    import bmc_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SHORT_MAX = DEF_SHORT_MAX,
    parameter int LONG_MAX  = DEF_LONG_MAX
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      enable,
    input  logic      active,
    input  logic      any_edge,
    output iv_class_t iv_class,
    output logic      iv_strobe
);

    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
    localparam logic [CNT_W-1:0] SHORT_LIM   = CNT_W'(SHORT_MAX);
    localparam logic [CNT_W-1:0] LONG_LIM    = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(LONG_MAX + 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (any_edge) begin
            // The edge cycle itself is cycle 1 of the next interval.
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        iv_class  = NONE;
        iv_strobe = 1'b0;
        if (enable) begin
            if (any_edge) begin
                iv_strobe = 1'b1;
                if (cnt == '0) begin
                    iv_class = NONE;        // first edge after flush/reset
                end else if (cnt <= SHORT_LIM) begin
                    iv_class = SHORT;
                end else if (cnt <= LONG_LIM) begin
                    iv_class = LONG;
                end else if (active) begin
                    iv_class = TIMEOUT;     // edge landed on/after the timeout cycle
                end
            end else if (active && cnt == TIMEOUT_LIM) begin
                iv_strobe = 1'b1;
                iv_class  = TIMEOUT;
            end
        end
    end

endmodule

// File: rtl/bmc_decode_ctrl.sv
// -----------------------------------------------------------------------------
// bmc_decode_ctrl
// Biphase-mark decode controller: times intervals between edges, runs the
// lock/framing FSM and presents decoded bits on a one-entry valid/ready
// output register.
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   enable             : low = synchronous flush to IDLE (clears valid,
//                        locked, overrun and the interval counter)
//   pos_edge, neg_edge : edge pulses from the edge detector (OR-ed)
//   bit_out, bit_valid : decoded bit and its valid flag
//   bit_ready          : consumer accepts bit_out this cycle
//   locked             : bit-boundary alignment established
//   error              : one-cycle pulse on framing error or timeout
//   overrun            : sticky, a decoded bit was dropped
//   err_count          : (only with BMC_STATS_EN) saturating error counter
// Configuration macro: BMC_STATS_EN.
// -----------------------------------------------------------------------------
module bmc_decode_ctrl
    import bmc_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SHORT_MAX = DEF_SHORT_MAX,
    parameter int LONG_MAX  = DEF_LONG_MAX
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pos_edge,
    input  logic        neg_edge,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        locked,
    output logic        error,
    output logic        overrun
`ifdef BMC_STATS_EN
    ,
    output logic [15:0] err_count
`endif
);

    state_t    state, state_n;
    iv_class_t iv_class;
    logic      iv_strobe;
    logic      locked_n;
    logic      error_n;
    logic      emit;
    logic      emit_bit;

    interval_timer #(
        .CNT_W     (CNT_W),
        .SHORT_MAX (SHORT_MAX),
        .LONG_MAX  (LONG_MAX)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .active    (state != IDLE),
        .any_edge  (pos_edge | neg_edge),
        .iv_class  (iv_class),
        .iv_strobe (iv_strobe)
    );

    // FSM state and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            locked <= 1'b0;
            error  <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            locked <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= state_n;
            locked <= locked_n;
            error  <= error_n;
        end
    end

    // Next-state logic and bit emission.
    always_comb begin
        state_n  = state;
        locked_n = locked;
        error_n  = 1'b0;
        emit     = 1'b0;
        emit_bit = 1'b0;
        if (iv_strobe) begin
            if (iv_class == TIMEOUT) begin
                state_n  = IDLE;
                locked_n = 1'b0;
                error_n  = 1'b1;
            end else begin
                case (state)
                    IDLE: state_n = SYNC;
                    SYNC: begin
                        // A full-bit interval can only span a bit cell, so it
                        // marks a bit boundary; half-bit intervals are ambiguous.
                        if (iv_class == LONG) begin
                            state_n  = BIT_START;
                            locked_n = 1'b1;
                        end
                    end
                    BIT_START: begin
                        if (iv_class == LONG) begin
                            emit     = 1'b1;
                            emit_bit = 1'b0;
                        end else if (iv_class == SHORT) begin
                            state_n = HALF;
                        end
                    end
                    HALF: begin
                        if (iv_class == SHORT) begin
                            emit     = 1'b1;
                            emit_bit = 1'b1;
                            state_n  = BIT_START;
                        end else if (iv_class == LONG) begin
                            // Mid-cell transition followed by a full cell:
                            // alignment is lost, re-acquire from SYNC.
                            state_n  = SYNC;
                            locked_n = 1'b0;
                            error_n  = 1'b1;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // One-entry output register. A new bit replaces the held one only when
    // the held one is being accepted in the same cycle; otherwise it is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (!enable) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit) begin
            if (!bit_valid || bit_ready) begin
                bit_out   <= emit_bit;
                bit_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (bit_ready) begin
            bit_valid <= 1'b0;
        end
    end

`ifdef BMC_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (!enable) begin
            err_count <= '0;
        end else if (error_n && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bmc_decode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bmc_decode_ctrl
// Self-checking bench for bmc_decode_ctrl with SHORT_MAX=12, LONG_MAX=24,
// half-bit 8 cycles, full bit 16 cycles. Expected decoded bits are queued as
// stimulus is driven and popped by a monitor whenever a bit is handed over.
// -----------------------------------------------------------------------------
module tb_bmc_decode_ctrl;

    logic clock     = 1'b0;
    logic reset_n   = 1'b0;
    logic enable    = 1'b0;
    logic pos_edge  = 1'b0;
    logic neg_edge  = 1'b0;
    logic bit_ready = 1'b0;
    logic bit_out, bit_valid, locked, error, overrun;
`ifdef BMC_STATS_EN
    logic [15:0] err_count;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    bit   exp_q[$];
    bit   exp_bit;
    logic edge_pol    = 1'b0;

    bmc_decode_ctrl #(
        .CNT_W     (8),
        .SHORT_MAX (12),
        .LONG_MAX  (24)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .locked    (locked),
        .error     (error),
        .overrun   (overrun)
`ifdef BMC_STATS_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a handshake happens on the posedge after a negedge that
    // sees bit_valid && bit_ready.
    always @(negedge clock) begin
        if (reset_n && bit_valid && bit_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL bit_stream: got bit %0b, expected no bit", bit_out);
            end else begin
                exp_bit = exp_q.pop_front();
                if (bit_out !== exp_bit) begin
                    miscompares++;
                    $display("FAIL bit_stream: got %0b, expected %0b", bit_out, exp_bit);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a one-cycle edge pulse sampled at the next posedge; alternate
    // polarity, or drive both lines at once when requested.
    task automatic pulse(input bit both);
        if (both) begin
            pos_edge = 1'b1;
            neg_edge = 1'b1;
        end else if (edge_pol) begin
            neg_edge = 1'b1;
        end else begin
            pos_edge = 1'b1;
        end
        edge_pol = ~edge_pol;
        tick();
        pos_edge = 1'b0;
        neg_edge = 1'b0;
    endtask

    // Next edge lands exactly `gap` cycles after the previous one.
    task automatic gap_edge(input int gap, input bit both = 1'b0);
        repeat (gap - 1) tick();
        pulse(both);
    endtask

    task automatic flush();
        enable = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    task automatic lock_on();
        pulse(1'b0);
        gap_edge(16);
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d bits still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({bit_out, bit_valid, locked, error, overrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_values: got %b, expected 00000",
                     {bit_out, bit_valid, locked, error, overrun});
        end
        @(negedge clock);
        reset_n   = 1'b1;
        enable    = 1'b1;
        bit_ready = 1'b0;
        repeat (5) tick();
        vectors++;
        if ({bit_out, bit_valid, locked, error, overrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b, expected 00000",
                     {bit_out, bit_valid, locked, error, overrun});
        end
        // Build a locked stream with a held bit, then reset mid-bit.
        lock_on();
        gap_edge(16);
        vectors++;
        if ({bit_valid, locked} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_prep: valid,locked got %b, expected 11", {bit_valid, locked});
        end
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bit_out, bit_valid, locked, error, overrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_async: got %b, expected 00000",
                     {bit_out, bit_valid, locked, error, overrun});
        end
        repeat (2) tick();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) tick();
        vectors++;
        if ({bit_out, bit_valid, locked, error, overrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_release: got %b, expected 00000",
                     {bit_out, bit_valid, locked, error, overrun});
        end
    endtask

    task automatic test_lock_zeros();
        flush();
        bit_ready = 1'b1;
        pulse(1'b0);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_sync: locked got %b, expected 0", locked);
        end
        gap_edge(16);
        vectors++;
        if ({locked, bit_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL lock_set: locked,valid got %b, expected 10", {locked, bit_valid});
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(1'b0);
            gap_edge(16, i == 1);
            vectors++;
            if ({bit_valid, bit_out} !== 2'b10) begin
                miscompares++;
                $display("FAIL zero_%0d: valid,bit got %b, expected 10", i, {bit_valid, bit_out});
            end
        end
        drain("lock_zeros");
    endtask

    task automatic test_decode_one();
        flush();
        bit_ready = 1'b1;
        lock_on();
        gap_edge(8);
        vectors++;
        if (bit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL one_mid: valid got %b, expected 0", bit_valid);
        end
        exp_q.push_back(1'b1);
        gap_edge(8);
        vectors++;
        if ({bit_valid, bit_out} !== 2'b11) begin
            miscompares++;
            $display("FAIL one_bit: valid,bit got %b, expected 11", {bit_valid, bit_out});
        end
        drain("decode_one");
    endtask

    // Interval boundaries: 12 is short, 13 and 24 are long, 1 is short.
    task automatic test_boundaries();
        flush();
        bit_ready = 1'b1;
        pulse(1'b0);
        gap_edge(12);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL bound_12: locked got %b, expected 0", locked);
        end
        gap_edge(13);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL bound_13: locked got %b, expected 1", locked);
        end
        exp_q.push_back(1'b0);
        gap_edge(24);
        exp_q.push_back(1'b1);
        gap_edge(12);
        gap_edge(1);
        vectors++;
        if ({bit_valid, bit_out, error} !== 3'b110) begin
            miscompares++;
            $display("FAIL bound_short1: valid,bit,error got %b, expected 110",
                     {bit_valid, bit_out, error});
        end
        drain("boundaries");
    endtask

    task automatic test_timeout();
        int first_err = -1;
        int n_err     = 0;
        flush();
        bit_ready = 1'b1;
        lock_on();
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (error === 1'b1) begin
                n_err++;
                if (first_err < 0) first_err = i;
            end
        end
        vectors++;
        if (first_err != 25 || n_err != 1) begin
            miscompares++;
            $display("FAIL timeout_pulse: first at %0d count %0d, expected 25 count 1",
                     first_err, n_err);
        end
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_unlock: locked got %b, expected 0", locked);
        end
`ifdef BMC_STATS_EN
        vectors++;
        if (err_count !== 16'd1) begin
            miscompares++;
            $display("FAIL timeout_count: err_count got %0d, expected 1", err_count);
        end
`endif
        pulse(1'b0);
        gap_edge(16);
        vectors++;
        if ({locked, error} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_relock: locked,error got %b, expected 10", {locked, error});
        end
        drain("timeout");
    endtask

    task automatic test_framing_error();
        flush();
        bit_ready = 1'b1;
        lock_on();
        gap_edge(8);
        gap_edge(16);
        vectors++;
        if ({error, locked, bit_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL frame_err: error,locked,valid got %b, expected 100",
                     {error, locked, bit_valid});
        end
`ifdef BMC_STATS_EN
        vectors++;
        if (err_count !== 16'd1) begin
            miscompares++;
            $display("FAIL frame_count: err_count got %0d, expected 1", err_count);
        end
`endif
        tick();
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_pulse: error got %b, expected 0", error);
        end
        gap_edge(15);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_relock: locked got %b, expected 1", locked);
        end
        drain("framing");
    endtask

    // Held bit accepted in the same cycle a new bit is emitted.
    task automatic test_back_to_back();
        flush();
        bit_ready = 1'b0;
        lock_on();
        exp_q.push_back(1'b0);
        gap_edge(16);
        gap_edge(8);
        exp_q.push_back(1'b1);
        repeat (7) tick();
        pos_edge  = 1'b1;
        bit_ready = 1'b1;
        tick();
        pos_edge = 1'b0;
        vectors++;
        if ({bit_valid, bit_out, overrun} !== 3'b110) begin
            miscompares++;
            $display("FAIL b2b_replace: valid,bit,overrun got %b, expected 110",
                     {bit_valid, bit_out, overrun});
        end
        tick();
        vectors++;
        if (bit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_consume: valid got %b, expected 0", bit_valid);
        end
        drain("back_to_back");
    endtask

    task automatic test_backpressure();
        flush();
        bit_ready = 1'b0;
        lock_on();
        exp_q.push_back(1'b0);
        gap_edge(16);
        gap_edge(8);
        gap_edge(8);
        repeat (3) tick();
        vectors++;
        if ({bit_valid, bit_out, overrun} !== 3'b101) begin
            miscompares++;
            $display("FAIL bp_hold: valid,bit,overrun got %b, expected 101",
                     {bit_valid, bit_out, overrun});
        end
        bit_ready = 1'b1;
        tick();
        vectors++;
        if ({bit_valid, overrun} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_consume: valid,overrun got %b, expected 01", {bit_valid, overrun});
        end
        flush();
        vectors++;
        if ({bit_valid, locked, overrun} !== 3'b000) begin
            miscompares++;
            $display("FAIL bp_flush: valid,locked,overrun got %b, expected 000",
                     {bit_valid, locked, overrun});
        end
        drain("backpressure");
    endtask

    initial begin
        test_reset();
        test_lock_zeros();
        test_decode_one();
        test_boundaries();
        test_timeout();
        test_framing_error();
        test_back_to_back();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bmc_decode_ctrl.md
# bmc_decode_ctrl

Biphase-mark (BMC) decode controller that sequences the single-bit edge-detect datapath. It consumes the per-cycle `pos_edge`/`neg_edge` pulses, times the interval between edges, and classifies each interval as a half-bit or full-bit period. A lock/framing state machine turns those intervals into decoded bits and presents them on a one-entry valid/ready output register. It sits directly downstream of the edge detector and upstream of the frame/byte assembler.

## Interface
- `CNT_W`, 8: interval counter width.
- `SHORT_MAX`, 12: intervals in 1..SHORT_MAX are half-bit ("short"). Must be < LONG_MAX.
- `LONG_MAX`, 24: intervals in SHORT_MAX+1..LONG_MAX are full-bit ("long"). Must be < 2^CNT_W − 1.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  decoder run; low = synchronous flush to IDLE.
- `pos_edge`  in  1  rising-edge pulse from edge detector.
- `neg_edge`  in  1  falling-edge pulse from edge detector.
- `bit_out`  out  1  decoded bit; meaningful only while `bit_valid`.
- `bit_valid`  out  1  output register holds an unconsumed bit.
- `bit_ready`  in  1  consumer accepts `bit_out` this cycle.
- `locked`  out  1  bit-boundary alignment established.
- `error`  out  1  one-cycle pulse on framing error or timeout.
- `overrun`  out  1  sticky: a decoded bit was dropped.

## Operation
- Edge = `pos_edge | neg_edge`; both high in one cycle counts as one edge.
- Interval counter `cnt`: on edge, sample interval = `cnt`, then `cnt <= 1`; else `cnt <= cnt + 1`, saturating at 2^CNT_W − 1. Edges at cycles t0 and t1 give an interval of t1 − t0.
- State machine:
  - IDLE: first edge → SYNC.
  - SYNC: short → stay; long → BIT_START, `locked` set, no bit emitted.
  - BIT_START: long → emit 0, stay; short → HALF.
  - HALF: short → emit 1, → BIT_START; long → `error`, → SYNC, `locked` cleared.
- Timeout: in any state other than IDLE, `cnt` exceeding LONG_MAX without an edge gives `error` pulse, → IDLE, `locked` cleared. The timeout is detected on the cycle `cnt` becomes LONG_MAX+1.
- Output register:
  - Emit with `bit_valid=0`: load and set valid.
  - Emit with `bit_valid=1 && bit_ready=1`: old bit accepted, new bit loaded, valid stays 1.
  - Emit with `bit_valid=1 && bit_ready=0`: new bit dropped, `overrun` set.
  - `bit_ready` with no emit: valid clears.
- `enable=0`: state IDLE, `cnt` 0, valid/locked/overrun cleared, edges ignored. `overrun` is cleared only this way or by reset.

## Timing
- Reset values: state IDLE, `cnt` 0, `bit_out` 0, `bit_valid` 0, `locked` 0, `error` 0, `overrun` 0.
- All outputs registered. `bit_valid`, `locked` and `error` change on the cycle after the closing edge or timeout cycle (1-cycle latency).
- Reset assertion mid-bit immediately forces reset values; no partial bit is emitted.
- `bit_out` stays stable while `bit_valid && !bit_ready`.

## Configuration
- `BMC_STATS_EN` defined: adds output `err_count` (16 bits), which increments on every `error` pulse, saturates at 0xFFFF, and is cleared by reset or `enable=0`.
- `BMC_STATS_EN` undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `bmc_pkg`: state typedef (IDLE, SYNC, BIT_START, HALF), interval-class typedef (NONE, SHORT, LONG, TIMEOUT), default SHORT_MAX/LONG_MAX constants.
- Sub-module `interval_timer`: the counter, saturation and classification. Outputs a class plus a strobe per edge or timeout. The FSM and output register stay in the top.

## Test plan
All scenarios use SHORT_MAX=12, LONG_MAX=24, half-bit 8 cycles, full bit 16 cycles.
- Reset: drive `reset_n=0` mid-stream → all outputs 0 within the same cycle; after release, stay 0 until edges arrive.
- Lock and 0s: edges at cycles 0, 16, 32, 48 → `locked=1` the cycle after 16. Bits 0, 0 valid the cycles after 32 and 48.
- Decode 1: after lock, edges +8, +16 → one bit 1, valid 1 cycle after the second edge. Intermediate edge emits nothing.
- Timeout: after lock, no edge for 25 cycles → `error` pulse once, `locked=0`. A subsequent edge enters SYNC.
- Framing error: after lock, intervals 8 then 16 → `error` pulse, `locked=0`, no bit emitted. The next long interval relocks.
- Backpressure: `bit_ready=0`, decode 0 then 1 → `bit_out=0` held, `overrun=1`. Raising `bit_ready` consumes 0 and `bit_valid` drops. With `BMC_STATS_EN`, the framing-error and timeout cases each increment `err_count` by 1.
